packet_filter: RTL and testbench
================================

# packet_filter

Receive-side packet classifier for the EER-RL node datapath. Each cycle it samples the field-decoded packet type and destination ID of a newly arrived packet. It emits one-cycle registered enable pulses to the downstream units: Q-table update, my-neighbour-info, known-cluster-head and reward. It also flags whether this node is the addressed destination. It sits between the packet field decoder and those learning and cluster-management blocks.

## Interface
Parameters:
- WORD_WIDTH, 16, width of node IDs.

Ports:
- clk  in  1  system clock, rising-edge active.
- nrst  in  1  reset, asynchronous, active-low; the block has one clock.
- fPktType  in  3  packet type code, valid when newpkt=1.
- newpkt  in  1  qualifier: a new packet is presented this cycle.
- myNodeID  in  WORD_WIDTH  this node's ID, quasi-static.
- destinationID  in  WORD_WIDTH  destination ID field of the presented packet.
- en_QTU  out  1  enable for the Q-table update unit.
- iAmDestination  out  1  the presented addressed packet targets this node.
- en_MNI  out  1  enable for the my-neighbour-info unit.
- en_KCH  out  1  enable for the known-cluster-head unit.
- en_reward  out  1  enable for the reward computation unit.

## Operation
- Type codes: 000 HB (heartbeat), 001 CHE (CH election), 010 INV (invitation), 011 MR (membership request), 100 CHT (CH timeslot), 101 DATA, 110 SOS, 111 none/idle.
- match = (destinationID == myNodeID), full-width equality, combinational.
- Decode, applied only when newpkt=1:
  - HB: en_MNI=1, en_reward=1. Broadcast, so iAmDestination=0.
  - CHE: en_KCH=1, iAmDestination=match.
  - INV: en_KCH=1. Broadcast, so iAmDestination=0.
  - MR: en_MNI=match, iAmDestination=match.
  - CHT: iAmDestination=match.
  - DATA: en_QTU=1, en_reward=1, iAmDestination=match.
  - SOS: en_QTU=1, iAmDestination=match.
  - 111: all outputs 0.
- Any output not listed for a type is 0.
- When newpkt=0, all outputs are 0 regardless of fPktType or IDs.
- An X or unknown myNodeID while newpkt=0 must not propagate to the outputs.

## Timing
- All five outputs are flops clocked by clk and cleared asynchronously by nrst=0.
- Reset value of every output is 0.
- Latency: inputs are sampled at rising edge N with newpkt=1, and the decoded outputs are valid from edge N until edge N+1.
- A single-cycle newpkt produces exactly one-cycle output pulses.
- Back-to-back packets (newpkt high on consecutive edges) are decoded independently each cycle. There is no internal state, so outputs may stay high or change every cycle.
- Reset asserted mid-packet clears the outputs immediately, independent of clk. The first packet is sampled at the first rising edge with nrst=1.
- No handshake or backpressure: every newpkt cycle is consumed.

## Test plan
- Reset: nrst=0 with fPktType=111 and newpkt=0 -> all outputs 0. Release nrst and idle 3 cycles -> all outputs still 0.
- HB: myNodeID=0x000C, fPktType=000, destinationID=0x0000, newpkt pulsed 1 cycle -> en_MNI=en_reward=1 for one cycle, others 0. Then all outputs 0.
- CHE mismatch then match:
  - destinationID=0x0008 -> en_KCH=1, iAmDestination=0.
  - destinationID=0x000C -> en_KCH=1, iAmDestination=1, each for one cycle.
- INV with destinationID=0x001C -> en_KCH=1 only. MR with destinationID=0x000D -> all outputs 0 (mismatch). CHT with destinationID=0x000C -> iAmDestination=1 only.
- DATA with destinationID=0x000D -> en_QTU=en_reward=1, iAmDestination=0. SOS with destinationID=0x0034 -> en_QTU=1 only.
- Async reset: assert nrst=0 mid-cycle while a DATA pulse is active -> outputs drop to 0 before the next clock edge. Also check two consecutive newpkt cycles (HB then DATA) -> outputs switch on the second edge with no gap.

Source files
------------

// File: rtl/packet_filter.sv
// Receive-side packet classifier: decodes packet type and destination match into
// registered one-cycle enable pulses for the learning and cluster-management units.
module packet_filter #(
    parameter int WORD_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic [2:0]            fPktType,
    input  logic                  newpkt,
    input  logic [WORD_WIDTH-1:0] myNodeID,
    input  logic [WORD_WIDTH-1:0] destinationID,
    output logic                  en_QTU,
    output logic                  iAmDestination,
    output logic                  en_MNI,
    output logic                  en_KCH,
    output logic                  en_reward
);

    typedef enum logic [2:0] {
        PKT_HB   = 3'b000,
        PKT_CHE  = 3'b001,
        PKT_INV  = 3'b010,
        PKT_MR   = 3'b011,
        PKT_CHT  = 3'b100,
        PKT_DATA = 3'b101,
        PKT_SOS  = 3'b110,
        PKT_NONE = 3'b111
    } pkt_type_t;

    logic match;
    logic nxt_qtu;
    logic nxt_dest;
    logic nxt_mni;
    logic nxt_kch;
    logic nxt_reward;

    assign match = (destinationID == myNodeID);

    // Nothing is decoded unless newpkt is high, so an unknown ID on idle cycles
    // never reaches the flops.
    always_comb begin
        nxt_qtu    = 1'b0;
        nxt_dest   = 1'b0;
        nxt_mni    = 1'b0;
        nxt_kch    = 1'b0;
        nxt_reward = 1'b0;
        if (newpkt) begin
            case (pkt_type_t'(fPktType))
                PKT_HB: begin
                    nxt_mni    = 1'b1;
                    nxt_reward = 1'b1;
                end
                PKT_CHE: begin
                    nxt_kch  = 1'b1;
                    nxt_dest = match;
                end
                PKT_INV: begin
                    nxt_kch = 1'b1;
                end
                PKT_MR: begin
                    nxt_mni  = match;
                    nxt_dest = match;
                end
                PKT_CHT: begin
                    nxt_dest = match;
                end
                PKT_DATA: begin
                    nxt_qtu    = 1'b1;
                    nxt_reward = 1'b1;
                    nxt_dest   = match;
                end
                PKT_SOS: begin
                    nxt_qtu  = 1'b1;
                    nxt_dest = match;
                end
                default: begin
                    nxt_qtu = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            en_QTU         <= 1'b0;
            iAmDestination <= 1'b0;
            en_MNI         <= 1'b0;
            en_KCH         <= 1'b0;
            en_reward      <= 1'b0;
        end else begin
            en_QTU         <= nxt_qtu;
            iAmDestination <= nxt_dest;
            en_MNI         <= nxt_mni;
            en_KCH         <= nxt_kch;
            en_reward      <= nxt_reward;
        end
    end

endmodule

// File: tb/tb_packet_filter.sv
// Self-checking bench for packet_filter: directed vector table, multi-cycle
// corner sequences and randomized packets against a mask-table reference model.
module tb_packet_filter;

    logic        clk;
    logic        nrst;
    logic [2:0]  fPktType;
    logic        newpkt;
    logic [15:0] myNodeID;
    logic [15:0] destinationID;
    logic        en_QTU;
    logic        iAmDestination;
    logic        en_MNI;
    logic        en_KCH;
    logic        en_reward;

    int vecCount;
    int errCount;

    // Output order everywhere: {en_QTU, iAmDestination, en_MNI, en_KCH, en_reward}
    typedef struct {
        string       name;
        logic [2:0]  ptype;
        logic [15:0] dest;
        logic        pkt;
        logic [4:0]  exp;
    } vec_t;

    vec_t vecs[$];

    logic [4:0] alwaysMask [8];
    logic [4:0] matchMask  [8];

    packet_filter #(.WORD_WIDTH(16)) dut (
        .clk            (clk),
        .nrst           (nrst),
        .fPktType       (fPktType),
        .newpkt         (newpkt),
        .myNodeID       (myNodeID),
        .destinationID  (destinationID),
        .en_QTU         (en_QTU),
        .iAmDestination (iAmDestination),
        .en_MNI         (en_MNI),
        .en_KCH         (en_KCH),
        .en_reward      (en_reward)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [4:0] refModel(input logic [2:0] t, input logic [15:0] dst,
                                            input logic [15:0] me, input logic pkt);
        if (!pkt) return 5'b00000;
        return alwaysMask[t] | ((dst == me) ? matchMask[t] : 5'b00000);
    endfunction

    task automatic applyStimulus(input logic [2:0] t, input logic [15:0] dst, input logic pkt);
        @(negedge clk);
        fPktType      = t;
        destinationID = dst;
        newpkt        = pkt;
    endtask

    task automatic checkOutput(input string name, input logic [4:0] exp);
        logic [4:0] act;
        act = {en_QTU, iAmDestination, en_MNI, en_KCH, en_reward};
        vecCount++;
        if (act !== exp) begin
            errCount++;
            $display("[TB] FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    initial begin
        vecCount = 0;
        errCount = 0;

        // Per-type behaviour: bits set unconditionally, and bits set only on ID match
        alwaysMask[0] = 5'b00101; matchMask[0] = 5'b00000;
        alwaysMask[1] = 5'b00010; matchMask[1] = 5'b01000;
        alwaysMask[2] = 5'b00010; matchMask[2] = 5'b00000;
        alwaysMask[3] = 5'b00000; matchMask[3] = 5'b01100;
        alwaysMask[4] = 5'b00000; matchMask[4] = 5'b01000;
        alwaysMask[5] = 5'b10001; matchMask[5] = 5'b01000;
        alwaysMask[6] = 5'b10000; matchMask[6] = 5'b01000;
        alwaysMask[7] = 5'b00000; matchMask[7] = 5'b00000;

        vecs.push_back('{"hb",          3'b000, 16'h0000, 1'b1, 5'b00101});
        vecs.push_back('{"hb_end",      3'b111, 16'h0000, 1'b0, 5'b00000});
        vecs.push_back('{"che_miss",    3'b001, 16'h0008, 1'b1, 5'b00010});
        vecs.push_back('{"che_hit",     3'b001, 16'h000C, 1'b1, 5'b01010});
        vecs.push_back('{"inv",         3'b010, 16'h001C, 1'b1, 5'b00010});
        vecs.push_back('{"mr_miss",     3'b011, 16'h000D, 1'b1, 5'b00000});
        vecs.push_back('{"mr_hit",      3'b011, 16'h000C, 1'b1, 5'b01100});
        vecs.push_back('{"cht_hit",     3'b100, 16'h000C, 1'b1, 5'b01000});
        vecs.push_back('{"data_miss",   3'b101, 16'h000D, 1'b1, 5'b10001});
        vecs.push_back('{"data_hit",    3'b101, 16'h000C, 1'b1, 5'b11001});
        vecs.push_back('{"sos_miss",    3'b110, 16'h0034, 1'b1, 5'b10000});
        vecs.push_back('{"none_type",   3'b111, 16'h000C, 1'b1, 5'b00000});
        vecs.push_back('{"no_pkt_data", 3'b101, 16'h000C, 1'b0, 5'b00000});
        vecs.push_back('{"hb_bcast",    3'b000, 16'h000C, 1'b1, 5'b00101});
        vecs.push_back('{"inv_bcast",   3'b010, 16'h000C, 1'b1, 5'b00010});

        nrst          = 1'b0;
        fPktType      = 3'b111;
        newpkt        = 1'b0;
        myNodeID      = 16'h000C;
        destinationID = 16'h0000;
        #12;
        checkOutput("reset", 5'b00000);

        @(negedge clk);
        nrst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checkOutput("idle_after_reset", 5'b00000);
        end

        $display("[TB] directed vectors");
        foreach (vecs[i]) begin
            applyStimulus(vecs[i].ptype, vecs[i].dest, vecs[i].pkt);
            @(posedge clk);
            #1;
            checkOutput(vecs[i].name, vecs[i].exp);
        end

        $display("[TB] async reset during DATA pulse");
        applyStimulus(3'b101, 16'h000C, 1'b1);
        @(posedge clk);
        #1;
        checkOutput("data_before_reset", 5'b11001);
        #2;
        nrst = 1'b0;
        #1;
        checkOutput("async_reset_clear", 5'b00000);
        @(negedge clk);
        newpkt = 1'b0;
        nrst   = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("after_reset_release", 5'b00000);

        $display("[TB] back-to-back HB then DATA");
        applyStimulus(3'b000, 16'h0000, 1'b1);
        @(posedge clk);
        #1;
        checkOutput("b2b_hb", 5'b00101);
        applyStimulus(3'b101, 16'h000D, 1'b1);
        @(posedge clk);
        #1;
        checkOutput("b2b_data", 5'b10001);
        applyStimulus(3'b111, 16'h0000, 1'b0);
        @(posedge clk);
        #1;
        checkOutput("b2b_end", 5'b00000);

        $display("[TB] randomized packets");
        for (int i = 0; i < 400; i++) begin
            logic [2:0]  t;
            logic [15:0] me;
            logic [15:0] dst;
            logic        pkt;
            t   = 3'($urandom_range(0, 7));
            me  = 16'($urandom);
            dst = ($urandom_range(0, 1) == 1) ? me : 16'($urandom);
            pkt = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            myNodeID = me;
            applyStimulus(t, dst, pkt);
            @(posedge clk);
            #1;
            checkOutput("random", refModel(t, dst, me, pkt));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
        $finish;
    end

endmodule
